// File: rtl/check_i_love_you.sv
// check_i_love_you
// Streaming detector for the case-insensitive phrase "iloveyou".
// Each clock at most one letter is accepted, from the uppercase lane or the
// lowercase lane, and echoed lowercased on out_flow one cycle later. The
// letter that completes the phrase is replaced by MATCH_CODE.
//
// Ports:
//   clk       rising-edge system clock
//   rst_n     asynchronous reset, ACTIVE-HIGH despite the name
//   cap_flow  uppercase lane, meaningful only for 'A'..'Z'
//   low_flow  lowercase lane, meaningful only for 'a'..'z'
//   out_flow  registered lowercase echo / MATCH_CODE / IDLE_CODE
//   state_dbg current match-progress state (number of phrase letters matched)
//
// Flow semantics: there is no valid/ready pair. A lane carries a letter in a
// given cycle exactly when its byte lies inside that lane's letter range;
// any other byte means "nothing offered". The block never back-pressures,
// and out_flow carries a byte every cycle (IDLE_CODE when nothing was taken).
module check_i_love_you #(
  parameter logic [7:0] MATCH_CODE = 8'h21,
  parameter logic [7:0] IDLE_CODE  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cap_flow,
  input  logic [7:0] low_flow,
  output logic [7:0] out_flow,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4,
    S5 = 4'd5,
    S6 = 4'd6,
    S7 = 4'd7,
    S8 = 4'd8
  } state_t;

  localparam logic [7:0] CHAR_I = 8'h69;
  localparam logic [7:0] CHAR_U = 8'h75;

  state_t     state;
  state_t     cur_state;
  logic       cap_valid;
  logic       low_valid;
  logic       acc_valid;
  logic [7:0] acc_char;
  logic [7:0] exp_char;

  // Letter that advances the match from a given state.
  function automatic logic [7:0] expected_char(input state_t s);
    logic [7:0] c;
    case (s)
      S0:      c = 8'h69; // i
      S1:      c = 8'h6C; // l
      S2:      c = 8'h6F; // o
      S3:      c = 8'h76; // v
      S4:      c = 8'h65; // e
      S5:      c = 8'h79; // y
      S6:      c = 8'h6F; // o
      S7:      c = 8'h75; // u
      default: c = 8'h69;
    endcase
    return c;
  endfunction

  always_comb begin
    cap_valid = (cap_flow >= 8'h41) && (cap_flow <= 8'h5A);
    low_valid = (low_flow >= 8'h61) && (low_flow <= 8'h7A);
    acc_valid = cap_valid || low_valid;
    // Uppercase lane has priority when both lanes carry a letter.
    acc_char  = cap_valid ? (cap_flow + 8'h20) : low_flow;
    // S8 and the unused codes above it behave as S0 for the current input,
    // which also makes them fall back to S0 on the next edge.
    cur_state = (state > S7) ? S0 : state;
    exp_char  = expected_char(cur_state);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= S0;
      out_flow <= IDLE_CODE;
    end else if (!acc_valid) begin
      // Idle cycle: progress is kept, so gaps inside the phrase are harmless.
      state    <= cur_state;
      out_flow <= IDLE_CODE;
    end else if (cur_state == S7 && acc_char == CHAR_U) begin
      // Phrase complete. 'u' cannot start a new phrase, so no overlap.
      state    <= S0;
      out_flow <= MATCH_CODE;
    end else if (acc_char == exp_char) begin
      state    <= state_t'(cur_state + 4'd1);
      out_flow <= acc_char;
    end else begin
      // 'i' is the only prefix of the phrase that can restart a broken match.
      state    <= (acc_char == CHAR_I) ? S1 : S0;
      out_flow <= acc_char;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_check_i_love_you.sv
module tb_check_i_love_you;

  logic       clk;
  logic       rst_n;
  logic [7:0] cap_flow;
  logic [7:0] low_flow;
  logic [7:0] out_flow;
  logic [3:0] state_dbg;

  logic [7:0] exp_q[$];
  int         n_checks;
  int         n_pass;
  bit         stim_done;

  check_i_love_you dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_flow  (cap_flow),
    .low_flow  (low_flow),
    .out_flow  (out_flow),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 8'h%02h, expected 8'h%02h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; the expected echo for the following
  // rising edge is queued at the same time.
  task automatic drive(input logic [7:0] cap, input logic [7:0] low,
                       input logic [7:0] exp, input logic rst_v = 1'b0);
    @(negedge clk);
    rst_n    = rst_v;
    cap_flow = cap;
    low_flow = low;
    exp_q.push_back(exp);
  endtask

  task automatic drive_low(input string s, input string exp_s);
    for (int i = 0; i < s.len(); i++) drive(8'h00, s[i], exp_s[i]);
  endtask

  task automatic check_state(input string name, input logic [3:0] exp);
    @(posedge clk);
    #2;
    compare(name, {4'h0, state_dbg}, {4'h0, exp});
  endtask

  // Short reset pulse between edges: outputs must clear without a clock.
  task automatic pulse_reset;
    @(negedge clk);
    cap_flow = 8'h00;
    low_flow = 8'h00;
    rst_n    = 1'b1;
    #1;
    compare("async_rst_out", out_flow, 8'h00);
    compare("async_rst_state", {4'h0, state_dbg}, 8'h00);
    #1;
    rst_n = 1'b0;
    exp_q.push_back(8'h00);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) compare("out_flow", out_flow, exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_pass    = 0;
    stim_done = 1'b0;
    rst_n     = 1'b1;
    cap_flow  = 8'h49;
    low_flow  = 8'h6C;
    #1;
    compare("reset_out", out_flow, 8'h00);
    compare("reset_state", {4'h0, state_dbg}, 8'h00);

    // Reset held for two cycles with letters on both lanes.
    drive(8'h49, 8'h6C, 8'h00, 1'b1);
    drive(8'h49, 8'h6C, 8'h00, 1'b1);

    // Pure lowercase phrase.
    drive_low("iloveyou", "iloveyo!");

    // Mixed case with gaps.
    drive(8'h49, 8'h00, 8'h69);   // 'I'
    drive(8'h20, 8'h20, 8'h00);   // space on both lanes
    drive_low("love", "love");
    drive(8'h00, 8'h00, 8'h00);   // idle
    drive(8'h59, 8'h00, 8'h79);   // 'Y'
    drive_low("ou", "o!");

    // Priority: uppercase lane wins.
    drive(8'h58, 8'h69, 8'h78);
    check_state("priority_state", 4'd0);

    // Lane range boundaries and wrong-case codes are idle.
    drive(8'h40, 8'h60, 8'h00);
    drive(8'h5B, 8'h7B, 8'h00);
    drive(8'h69, 8'h49, 8'h00);
    drive(8'h41, 8'h00, 8'h61);   // 'A'
    drive(8'h00, 8'h7A, 8'h7A);   // 'z'
    drive(8'h5A, 8'h00, 8'h7A);   // 'Z'
    drive(8'h00, 8'h61, 8'h61);   // 'a'

    // Restart on 'i'.
    drive_low("ilovi", "ilovi");
    check_state("restart_state", 4'd1);
    drive_low("loveyou", "loveyo!");

    // Mismatch.
    drive_low("ilovx", "ilovx");
    check_state("mismatch_state", 4'd0);

    // Reset mid-phrase discards progress.
    drive_low("ilov", "ilov");
    pulse_reset();
    drive_low("eyou", "eyou");

    // Back-to-back phrases.
    drive_low("iloveyouiloveyou", "iloveyo!iloveyo!");
    drive(8'h00, 8'h00, 8'h00);
    stim_done = 1'b1;
  end

  // ---------------- final report ----------------
  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected outputs still queued, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
